// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared definitions for the writeback arbiter slice.
//   DefDataW / DefAddrW : default write-data and register-address widths
//   RegZero             : architectural zero register (writes are consumed, never enabled)
//   grant_e             : per-cycle grant source selected by the arbiter
package wb_arbiter_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam logic [4:0]  RegZero  = 5'd0;

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    GntAlu  = 2'd1,
    GntLsu  = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with separate occupancy counter.
//   clk, rstn      : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    : write strobe and data (caller guarantees !full)
//   pop, rdata     : read strobe and head data (caller guarantees !empty)
//   full, empty    : occupancy flags
//   count          : occupancy 0..DEPTH
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (push && !pop) cnt_d = cnt_q + CntW'(1);
    if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging ALU and buffered LSU results into a single
// registered register-file write per cycle, with bounded LSU starvation.
//   clk, rstn                   : clock, asynchronous active-low reset
//   alu_valid/ready, alu_wa/wd  : single-cycle ALU result handshake
//   lsu_valid/ready, lsu_wa/wd  : load result handshake into the LSU buffer
//   rf_we, rf_wa, rf_wd         : registered write port (also the forwarding tap)
//   lsu_pending                 : LSU buffer occupancy
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned LSU_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                alu_valid,
  output logic                                alu_ready,
  input  logic [ADDR_W-1:0]                   alu_wa,
  input  logic [DATA_W-1:0]                   alu_wd,
  input  logic                                lsu_valid,
  output logic                                lsu_ready,
  input  logic [ADDR_W-1:0]                   lsu_wa,
  input  logic [DATA_W-1:0]                   lsu_wd,
  output logic                                rf_we,
  output logic [ADDR_W-1:0]                   rf_wa,
  output logic [DATA_W-1:0]                   rf_wd,
  output logic [$clog2(LSU_FIFO_DEPTH+1)-1:0] lsu_pending
);

  localparam int unsigned EntW = ADDR_W + DATA_W;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntW-1:0]   fifo_head;
  logic [ADDR_W-1:0] head_wa;
  logic [DATA_W-1:0] head_wd;

  logic [StvW-1:0]   starve_q, starve_d;
  logic              lsu_force;
  grant_e            grant;

  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_wa_d;
  logic [DATA_W-1:0] rf_wd_d;

  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && lsu_ready;

  wb_fifo #(
    .WIDTH (EntW),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .wdata ({lsu_wa, lsu_wd}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (lsu_pending)
  );

  assign {head_wa, head_wd} = fifo_head;

  // The FIFO head only preempts the ALU once it has waited STARVE_LIMIT cycles.
  assign lsu_force = !fifo_empty && (starve_q == StvW'(STARVE_LIMIT));
  assign alu_ready = !lsu_force;

  always_comb begin
    grant = GntNone;
    if (lsu_force) begin
      grant = GntLsu;
    end else if (alu_valid) begin
      grant = GntAlu;
    end else if (!fifo_empty) begin
      grant = GntLsu;
    end
  end

  assign fifo_pop = (grant == GntLsu);

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (starve_q != StvW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StvW'(1);
    end
  end

  // Address/data hold when idle; x0 targets are consumed but never enabled.
  always_comb begin
    rf_we_d = 1'b0;
    rf_wa_d = rf_wa;
    rf_wd_d = rf_wd;
    unique case (grant)
      GntAlu: begin
        rf_we_d = (alu_wa != ADDR_W'(RegZero));
        rf_wa_d = alu_wa;
        rf_wd_d = alu_wd;
      end
      GntLsu: begin
        rf_we_d = (head_wa != ADDR_W'(RegZero));
        rf_wa_d = head_wa;
        rf_wd_d = head_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we    <= rf_we_d;
      rf_wa    <= rf_wa_d;
      rf_wd    <= rf_wd_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [1:0]  lsu_pending;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tb_rf [32];

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W         (32),
    .ADDR_W         (5),
    .LSU_FIFO_DEPTH (2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_wa      (alu_wa),
    .alu_wd      (alu_wd),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_wa      (lsu_wa),
    .lsu_wd      (lsu_wd),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .lsu_pending (lsu_pending)
  );

  // Reference register file fed by the write port.
  always @(posedge clk) begin
    if (rf_we && rf_wa != 5'd0) tb_rf[rf_wa] <= rf_wd;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backpressure scenario expectations, one entry per cycle.
  logic [4:0]  exp_wa  [16];
  logic [31:0] exp_wd  [16];
  logic        exp_ar  [16];
  logic        exp_lr  [16];
  logic [4:0]  push_wa [3];
  logic [31:0] push_wd [3];

  initial begin
    int lsu_idx;
    int stale;
    logic hs;

    for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    rstn = 1'b0;
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h1;
    lsu_valid = 1'b1; lsu_wa = 5'd9; lsu_wd = 32'h2;

    // 1. Reset with valids asserted.
    repeat (3) tick();
    check_val("rst_rf_we", 64'(rf_we), 64'd0);
    check_val("rst_rf_wa", 64'(rf_wa), 64'd0);
    check_val("rst_pending", 64'(lsu_pending), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rstn = 1'b1;
    #1;
    check_val("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check_val("rst_pending_rel", 64'(lsu_pending), 64'd0);

    // 2. ALU alone.
    tick();
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'hDEADBEEF;
    #1;
    check_val("alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_val("alu_rf_we", 64'(rf_we), 64'd1);
    check_val("alu_rf_wa", 64'(rf_wa), 64'd3);
    check_val("alu_rf_wd", 64'(rf_wd), 64'hDEADBEEF);
    tick();
    check_val("alu_rf_read", 64'(tb_rf[3]), 64'hDEADBEEF);
    check_val("idle_rf_we", 64'(rf_we), 64'd0);
    check_val("idle_rf_wa_hold", 64'(rf_wa), 64'd3);

    // 3. x0 write is consumed but not enabled.
    alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'h1234;
    #1;
    check_val("x0_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_val("x0_rf_we", 64'(rf_we), 64'd0);
    check_val("x0_rf_wa", 64'(rf_wa), 64'd0);

    // 4. Starvation: one LSU entry waits four ALU grants, then preempts.
    lsu_valid = 1'b1; lsu_wa = 5'd7; lsu_wd = 32'h55;
    #1;
    check_val("stv_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    lsu_valid = 1'b0;
    check_val("stv_pending", 64'(lsu_pending), 64'd1);
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_wa = 5'(10 + i); alu_wd = 32'(100 + i);
      #1;
      check_val($sformatf("stv_alu_ready%0d", i), 64'(alu_ready), 64'd1);
      tick();
      check_val($sformatf("stv_alu_wa%0d", i), 64'(rf_wa), 64'(10 + i));
    end
    #1;
    check_val("stv_force_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    check_val("stv_lsu_we", 64'(rf_we), 64'd1);
    check_val("stv_lsu_wa", 64'(rf_wa), 64'd7);
    check_val("stv_lsu_wd", 64'(rf_wd), 64'h55);
    check_val("stv_pending0", 64'(lsu_pending), 64'd0);
    #1;
    check_val("stv_alu_ready_back", 64'(alu_ready), 64'd1);
    tick();
    check_val("stv_alu_after", 64'(rf_wa), 64'd13);
    alu_valid = 1'b0;
    tick();

    // 5. Backpressure: three pushes against a continuously valid ALU.
    push_wa[0] = 5'd20; push_wd[0] = 32'hA0;
    push_wa[1] = 5'd21; push_wd[1] = 32'hB0;
    push_wa[2] = 5'd22; push_wd[2] = 32'hC0;
    for (int i = 0; i < 16; i++) begin
      exp_wa[i] = 5'd9; exp_wd[i] = 32'(i); exp_ar[i] = 1'b1; exp_lr[i] = 1'b1;
    end
    exp_wa[5]  = 5'd20; exp_wd[5]  = 32'hA0; exp_ar[5]  = 1'b0;
    exp_wa[10] = 5'd21; exp_wd[10] = 32'hB0; exp_ar[10] = 1'b0;
    exp_wa[15] = 5'd22; exp_wd[15] = 32'hC0; exp_ar[15] = 1'b0;
    for (int i = 2; i <= 5; i++) exp_lr[i] = 1'b0;
    for (int i = 7; i <= 10; i++) exp_lr[i] = 1'b0;

    lsu_idx = 0;
    for (int i = 0; i < 16; i++) begin
      alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'(i);
      lsu_valid = (lsu_idx < 3);
      lsu_wa = push_wa[lsu_idx < 3 ? lsu_idx : 2];
      lsu_wd = push_wd[lsu_idx < 3 ? lsu_idx : 2];
      #1;
      check_val($sformatf("bp_alu_ready%0d", i), 64'(alu_ready), 64'(exp_ar[i]));
      check_val($sformatf("bp_lsu_ready%0d", i), 64'(lsu_ready), 64'(exp_lr[i]));
      hs = lsu_valid && lsu_ready;
      tick();
      if (hs) lsu_idx++;
      check_val($sformatf("bp_rf_wa%0d", i), 64'(rf_wa), 64'(exp_wa[i]));
      check_val($sformatf("bp_rf_wd%0d", i), 64'(rf_wd), 64'(exp_wd[i]));
    end
    check_val("bp_all_pushed", 64'(lsu_idx), 64'd3);
    check_val("bp_pending0", 64'(lsu_pending), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();

    // 6. Reset mid-run with two buffered entries.
    alu_valid = 1'b1; alu_wa = 5'd4; alu_wd = 32'h44;
    lsu_valid = 1'b1; lsu_wa = 5'd25; lsu_wd = 32'hD0;
    tick();
    lsu_wa = 5'd26; lsu_wd = 32'hE0;
    tick();
    lsu_valid = 1'b0;
    check_val("mr_pending2", 64'(lsu_pending), 64'd2);
    check_val("mr_rf_we_pre", 64'(rf_we), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_val("mr_rf_we_async", 64'(rf_we), 64'd0);
    check_val("mr_pending_async", 64'(lsu_pending), 64'd0);
    alu_valid = 1'b0;
    tick();
    rstn = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rf_we) stale++;
    end
    check_val("mr_no_stale", 64'(stale), 64'd0);
    check_val("mr_lsu_ready", 64'(lsu_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
